do_chu_ky: RTL and testbench
============================

Name: do_chu_ky

Overview:
- Measures a slow external square wave in clk cycles, such as the 1 Hz tick from the board's pulse divider or an external pulse source.
- Reports the period and the high time of the wave.
- Flags whether the period is within tolerance of the nominal M cycles, and flags loss of signal.
- Sits on the input side of the status/display path; the receiving-end counterpart to the divider that generates such waves.

Parameters:
- N, 30, width of all cycle counters and measurement outputs.
- M, 50000000, nominal period in clk cycles (1 Hz at 50 MHz).
- TOL, 1000, allowed |period − M| for freq_ok.
- TMAX, 100000000, cycles without a rising edge before loss is declared; must be < 2^N.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- f_in  input  1  asynchronous square wave to measure.
- period  output  N  last measured rise-to-rise period, in clk cycles.
- high_time  output  N  last measured rise-to-fall high time, in clk cycles.
- valid  output  1  one-cycle strobe when period/high_time update.
- freq_ok  output  1  |period − M| <= TOL for the last measurement.
- lost  output  1  no rising edge for TMAX cycles.

Behaviour:
- Clocking: one clock. Reset is synchronous and active-high.
- Reset values: period=0, high_time=0, valid=0, freq_ok=0, lost=0, FSM=S_IDLE, counters=0, synchronizer flops=0.
- Input conditioning:
  - f_in passes through a 2-flop synchronizer giving s; s_d is s delayed one cycle.
  - rise = s & ~s_d; fall = ~s & s_d.
  - An f_in edge produces its rise/fall strobe 3 clk edges after the edge is first sampled.
- Counters:
  - cnt is loaded with 1 on rise, else incremented, saturating at TMAX.
  - hcnt is loaded with 1 on rise, incremented while in S_HIGH, frozen otherwise.
  - Rises P cycles apart give cnt=P at the second rise. A high phase of H synced cycles gives hcnt=H at fall.
- FSM states:
  - S_IDLE: waits for the first rise; rise -> S_HIGH. Nothing is output, because the first edge has no reference.
  - S_HIGH: fall -> latch high_time<=hcnt, go to S_LOW.
  - S_HIGH: rise is not possible without a fall, so it is ignored.
  - S_LOW: rise -> latch period<=cnt, assert valid for one cycle, update freq_ok, clear lost, go to S_HIGH.
  - S_HIGH or S_LOW: cnt==TMAX -> lost<=1, go to S_IDLE; period/high_time hold their old values and valid is not pulsed.
- Output timing: outputs are registered on the clock edge that samples rise. valid is high in the following cycle only.
- freq_ok: compared in N+1 bits; no wrap on period<M.
- Boundary conditions:
  - rise and cnt==TMAX in the same cycle: rise wins; it is treated as a normal measurement if in S_LOW.
  - fall in S_IDLE: ignored.
  - f_in stuck high: cnt reaches TMAX, lost=1, FSM returns to S_IDLE. The next rise restarts measurement, and lost clears only on the next valid.
  - reset mid-measurement: all state returns to reset values on the next edge; the first valid needs two further rises.
  - Back-to-back minimum wave (period 2 synced cycles): measured correctly as period=2, high_time=1.

Optional Feature:
- Macro: DUTY_CHECK_EN.
- With the macro defined:
  - Extra output duty_ok (1 bit, reset 0).
  - Updated on the same edge as valid.
  - duty_ok = |2*high_time − period| <= TOL, computed in N+2 bits, using the high_time latched at the fall preceding this rise.
- Without the macro: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Parameters M=100, TOL=2, TMAX=250.
- Test 1: reset 5 cycles, then f_in with period 101 cycles, high 50 -> no valid on the first rise. Each later rise gives valid one cycle, period=101, high_time=50, freq_ok=1, lost=0.
- Test 2: f_in period 110 -> period=110, freq_ok=0. Switch to period 98 -> period=98, freq_ok=1.
- Test 3: f_in held low 300 cycles after a valid measurement -> lost=1 at cnt==250, no valid, period holds the last value. The next two rises 100 apart -> valid, period=100, lost=0.
- Test 4: assert reset for 1 cycle mid-high-phase -> all outputs 0 next cycle. The first valid arrives only on the second rise after reset.
- Test 5: f_in toggled every cycle (period 2) -> period=2, high_time=1, valid on every rise after the first.
- Test 6 (DUTY_CHECK_EN): period 100, high 50 -> duty_ok=1. High 45 -> duty_ok=0. Build without the macro -> compiles, no duty_ok port.

Source files
------------

// File: rtl/do_chu_ky.sv
// do_chu_ky: period / high-time meter for a slow external square wave.
//
// The asynchronous input f_in is synchronised and edge-detected. A free-running
// rise-to-rise counter and a high-phase counter are sampled by a small FSM.
// On every measured rising edge the meter publishes:
//   period    - cycles between the last two rising edges
//   high_time - cycles between the previous rising edge and the following fall
//   valid     - a one-cycle strobe
//   freq_ok   - whether period lies within TOL of the nominal M cycles
// lost is raised when TMAX cycles pass without a rising edge.
//
// Optional build macro DUTY_CHECK_EN adds the duty_ok output. duty_ok reports
// whether the wave is close to 50% duty (|2*high_time - period| <= TOL).
// Without the macro, the port and its logic are absent.

module do_chu_ky #(
    parameter int N    = 30,
    parameter int M    = 50000000,
    parameter int TOL  = 1000,
    parameter int TMAX = 100000000
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         f_in,
    output logic [N-1:0] period,
    output logic [N-1:0] high_time,
    output logic         valid,
    output logic         freq_ok,
    output logic         lost
`ifdef DUTY_CHECK_EN
    ,
    output logic         duty_ok
`endif
);

    // Counter limits and comparison constants, sized to the datapaths they feed.
    localparam logic [N-1:0] C_TMAX    = N'(TMAX);
    localparam logic [N-1:0] C_ONE     = N'(1);
    localparam logic [N:0]   C_M_EXT   = (N+1)'(M);
    localparam logic [N:0]   C_TOL_EXT = (N+1)'(TOL);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HIGH = 2'd1,
        S_LOW  = 2'd2
    } state_t;

    state_t       r_state;
    state_t       w_nextState;

    logic         r_sync1;
    logic         r_sync2;
    logic         r_syncDly;
    logic         w_rise;
    logic         w_fall;

    logic [N-1:0] r_cnt;
    logic [N-1:0] r_hcnt;
    logic         w_cntAtMax;

    logic         w_latchHigh;
    logic         w_latchPeriod;
    logic         w_setLost;

    logic [N-1:0] r_period;
    logic [N-1:0] r_highTime;
    logic         r_valid;
    logic         r_freqOk;
    logic         r_lost;

    logic [N:0]   w_cntExt;
    logic [N:0]   w_freqDiff;
    logic         w_freqOk;

    // Two-flop synchroniser on f_in plus one more stage for edge detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1   <= 1'b0;
            r_sync2   <= 1'b0;
            r_syncDly <= 1'b0;
        end else begin
            r_sync1   <= f_in;
            r_sync2   <= r_sync1;
            r_syncDly <= r_sync2;
        end
    end

    assign w_rise     = r_sync2 & ~r_syncDly;
    assign w_fall     = ~r_sync2 & r_syncDly;
    assign w_cntAtMax = (r_cnt == C_TMAX);

    // Rise-to-rise counter. Starts at 1 on a rise so that it reads P at the next
    // rise P cycles later. Saturates at TMAX, which doubles as the loss timer.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (w_rise) begin
            r_cnt <= C_ONE;
        end else if (!w_cntAtMax) begin
            r_cnt <= r_cnt + C_ONE;
        end
    end

    // High-phase counter. Runs only while the FSM sits in the high phase, so it
    // holds H in the cycle where the fall is seen.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_hcnt <= '0;
        end else if (w_rise) begin
            r_hcnt <= C_ONE;
        end else if ((r_state == S_HIGH) && (r_hcnt != C_TMAX)) begin
            r_hcnt <= r_hcnt + C_ONE;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic and the latch/loss strobes that drive the output registers.
    always_comb begin
        w_nextState   = r_state;
        w_latchHigh   = 1'b0;
        w_latchPeriod = 1'b0;
        w_setLost     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_rise) begin
                    w_nextState = S_HIGH;
                end
            end
            S_HIGH: begin
                if (w_fall) begin
                    w_latchHigh = 1'b1;
                    w_nextState = S_LOW;
                end else if (!w_rise && w_cntAtMax) begin
                    w_setLost   = 1'b1;
                    w_nextState = S_IDLE;
                end
            end
            S_LOW: begin
                if (w_rise) begin
                    w_latchPeriod = 1'b1;
                    w_nextState   = S_HIGH;
                end else if (w_cntAtMax) begin
                    w_setLost   = 1'b1;
                    w_nextState = S_IDLE;
                end
            end
            default: begin
                w_nextState = S_IDLE;
            end
        endcase
    end

    // Tolerance check of the period being latched. One extra bit lets the
    // absolute difference be formed without wrapping when the count is below M.
    always_comb begin
        w_cntExt = {1'b0, r_cnt};
        if (w_cntExt >= C_M_EXT) begin
            w_freqDiff = w_cntExt - C_M_EXT;
        end else begin
            w_freqDiff = C_M_EXT - w_cntExt;
        end
        w_freqOk = (w_freqDiff <= C_TOL_EXT);
    end

    // Measurement output registers. They are updated on the edge that samples the
    // rise or fall, and hold their values across signal loss.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_period   <= '0;
            r_highTime <= '0;
            r_valid    <= 1'b0;
            r_freqOk   <= 1'b0;
            r_lost     <= 1'b0;
        end else begin
            r_valid <= w_latchPeriod;
            if (w_latchHigh) begin
                r_highTime <= r_hcnt;
            end
            if (w_latchPeriod) begin
                r_period <= r_cnt;
                r_freqOk <= w_freqOk;
                r_lost   <= 1'b0;
            end else if (w_setLost) begin
                r_lost <= 1'b1;
            end
        end
    end

    assign period    = r_period;
    assign high_time = r_highTime;
    assign valid     = r_valid;
    assign freq_ok   = r_freqOk;
    assign lost      = r_lost;

`ifdef DUTY_CHECK_EN
    localparam logic [N+1:0] C_TOL_DUTY = (N+2)'(TOL);

    logic [N+1:0] w_twiceHigh;
    logic [N+1:0] w_periodExt;
    logic [N+1:0] w_dutyDiff;
    logic         w_dutyOk;
    logic         r_dutyOk;

    // Duty check: compare twice the high time from the preceding fall against the
    // period now being latched. Two extra bits hold 2*high_time without overflow.
    always_comb begin
        w_twiceHigh = {1'b0, r_highTime, 1'b0};
        w_periodExt = {2'b00, r_cnt};
        if (w_twiceHigh >= w_periodExt) begin
            w_dutyDiff = w_twiceHigh - w_periodExt;
        end else begin
            w_dutyDiff = w_periodExt - w_twiceHigh;
        end
        w_dutyOk = (w_dutyDiff <= C_TOL_DUTY);
    end

    // duty_ok is updated on the same edge as valid.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_dutyOk <= 1'b0;
        end else if (w_latchPeriod) begin
            r_dutyOk <= w_dutyOk;
        end
    end

    assign duty_ok = r_dutyOk;
`endif

endmodule

// File: tb/tb_do_chu_ky.sv
// tb_do_chu_ky: self-checking bench for do_chu_ky (M=100, TOL=2, TMAX=250).
// A timestamp-based reference model predicts every output every cycle. A table of
// wave shapes and a few hand-written sequences check the headline results.
// Build with DUTY_CHECK_EN defined to include the duty_ok checks.

module tb_do_chu_ky;

    localparam int N    = 30;
    localparam int M    = 100;
    localparam int TOL  = 2;
    localparam int TMAX = 250;

    logic         clk;
    logic         reset;
    logic         f_in;
    logic [N-1:0] period;
    logic [N-1:0] high_time;
    logic         valid;
    logic         freq_ok;
    logic         lost;
`ifdef DUTY_CHECK_EN
    logic         duty_ok;
`endif

    do_chu_ky #(
        .N   (N),
        .M   (M),
        .TOL (TOL),
        .TMAX(TMAX)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .f_in     (f_in),
        .period   (period),
        .high_time(high_time),
        .valid    (valid),
        .freq_ok  (freq_ok),
        .lost     (lost)
`ifdef DUTY_CHECK_EN
        ,
        .duty_ok  (duty_ok)
`endif
    );

    int totalChecks = 0;
    int badChecks   = 0;

    // Reference model state. Timestamps are posedge indices. A measured period is
    // the difference between two rise timestamps. The input is seen three samples
    // late: two synchroniser stages plus the edge-detect stage.
    typedef enum {M_IDLE, M_HIGH, M_LOW} modelState_t;
    modelState_t mState    = M_IDLE;
    logic [2:0]  mPipe     = 3'b000;
    int          pIdx      = 0;
    int          tRise     = 0;
    int          expPeriod = 0;
    int          expHigh   = 0;
    bit          expValid  = 1'b0;
    bit          expFreq   = 1'b0;
    bit          expLost   = 1'b0;
`ifdef DUTY_CHECK_EN
    bit          expDuty   = 1'b0;
    logic        capDuty;
`endif
    bit          monOn     = 1'b0;

    int           validSeen = 0;
    logic [N-1:0] capPeriod;
    logic [N-1:0] capHigh;
    logic         capFreq;

    typedef struct {
        int highLen;
        int lowLen;
        int reps;
        int expPeriod;
        int expHigh;
        bit expFreq;
        bit expDuty;
        int expValids;
    } vec_t;

    vec_t tbl[9];
    int   v0;

    function automatic int absInt(input int x);
        return (x < 0) ? -x : x;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
        totalChecks++;
        if (actual !== required) begin
            badChecks++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, required, pIdx);
        end
    endtask

    // One model step per clock edge, applying the measurement rules to the
    // delayed view of f_in.
    task automatic modelStep();
        logic s;
        logic sd;
        logic rise;
        logic fall;
        int   elapsed;
        pIdx++;
        if (reset === 1'b1) begin
            mState    = M_IDLE;
            mPipe     = 3'b000;
            expPeriod = 0;
            expHigh   = 0;
            expValid  = 1'b0;
            expFreq   = 1'b0;
            expLost   = 1'b0;
`ifdef DUTY_CHECK_EN
            expDuty   = 1'b0;
`endif
        end else begin
            s        = mPipe[1];
            sd       = mPipe[2];
            rise     = s & ~sd;
            fall     = ~s & sd;
            elapsed  = pIdx - tRise;
            expValid = 1'b0;
            case (mState)
                M_IDLE: begin
                    if (rise) begin
                        mState = M_HIGH;
                        tRise  = pIdx;
                    end
                end
                M_HIGH: begin
                    if (rise) begin
                        tRise = pIdx;
                    end else if (fall) begin
                        expHigh = elapsed;
                        mState  = M_LOW;
                    end else if (elapsed >= TMAX) begin
                        expLost = 1'b1;
                        mState  = M_IDLE;
                    end
                end
                M_LOW: begin
                    if (rise) begin
                        expPeriod = elapsed;
                        expValid  = 1'b1;
                        expFreq   = (absInt(elapsed - M) <= TOL);
`ifdef DUTY_CHECK_EN
                        expDuty   = (absInt(2 * expHigh - elapsed) <= TOL);
`endif
                        expLost   = 1'b0;
                        tRise     = pIdx;
                        mState    = M_HIGH;
                    end else if (elapsed >= TMAX) begin
                        expLost = 1'b1;
                        mState  = M_IDLE;
                    end
                end
                default: mState = M_IDLE;
            endcase
            mPipe = {mPipe[1:0], f_in};
        end
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model runs on every rising edge.
    initial begin
        forever begin
            @(posedge clk);
            modelStep();
        end
    end

    // Per-cycle comparison against the model, plus capture of each valid measurement.
    initial begin
        forever begin
            @(negedge clk);
            if (monOn) begin
                checkOutput("valid", 32'(valid), 32'(expValid));
                checkOutput("lost", 32'(lost), 32'(expLost));
                checkOutput("period", 32'(period), 32'(expPeriod));
                checkOutput("high_time", 32'(high_time), 32'(expHigh));
                checkOutput("freq_ok", 32'(freq_ok), 32'(expFreq));
`ifdef DUTY_CHECK_EN
                checkOutput("duty_ok", 32'(duty_ok), 32'(expDuty));
`endif
            end
            if (valid === 1'b1) begin
                validSeen++;
                capPeriod = period;
                capHigh   = high_time;
                capFreq   = freq_ok;
`ifdef DUTY_CHECK_EN
                capDuty   = duty_ok;
`endif
            end
        end
    end

    task automatic holdLevel(input logic lvl, input int n);
        f_in = lvl;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input int highLen, input int lowLen);
        holdLevel(1'b1, highLen);
        holdLevel(1'b0, lowLen);
    endtask

    task automatic checkZeroOutputs(input string tag);
        checkOutput({tag, " period"}, 32'(period), 32'd0);
        checkOutput({tag, " high_time"}, 32'(high_time), 32'd0);
        checkOutput({tag, " valid"}, 32'(valid), 32'd0);
        checkOutput({tag, " freq_ok"}, 32'(freq_ok), 32'd0);
        checkOutput({tag, " lost"}, 32'(lost), 32'd0);
    endtask

    initial begin
        int h;
        int l;
        reset = 1'b1;
        f_in  = 1'b0;

        tbl[0] = '{50, 51, 4, 101, 50, 1'b1, 1'b1, 3};
        tbl[1] = '{55, 55, 3, 110, 55, 1'b0, 1'b1, 3};
        tbl[2] = '{49, 49, 3, 98, 49, 1'b1, 1'b1, 3};
        tbl[3] = '{1, 1, 6, 2, 1, 1'b0, 1'b1, 6};
        tbl[4] = '{50, 50, 3, 100, 50, 1'b1, 1'b1, 3};
        tbl[5] = '{45, 55, 3, 100, 45, 1'b1, 1'b0, 3};
        tbl[6] = '{50, 47, 3, 97, 50, 1'b0, 1'b0, 3};
        tbl[7] = '{52, 50, 3, 102, 52, 1'b1, 1'b1, 3};
        tbl[8] = '{125, 125, 2, 250, 125, 1'b0, 1'b1, 2};

        // Reset state.
        repeat (5) @(posedge clk);
        #1;
        monOn = 1'b1;
        reset = 1'b0;
        @(negedge clk);
        checkZeroOutputs("reset");
        @(posedge clk);
        #1;

        // Table of wave shapes; each check looks at the last measurement of the record.
        for (int i = 0; i < 9; i++) begin
            v0 = validSeen;
            for (int r = 0; r < tbl[i].reps; r++) begin
                applyStimulus(tbl[i].highLen, tbl[i].lowLen);
            end
            holdLevel(1'b0, 4);
            checkOutput($sformatf("vec%0d valids", i), 32'(validSeen - v0), 32'(tbl[i].expValids));
            checkOutput($sformatf("vec%0d period", i), 32'(capPeriod), 32'(tbl[i].expPeriod));
            checkOutput($sformatf("vec%0d high_time", i), 32'(capHigh), 32'(tbl[i].expHigh));
            checkOutput($sformatf("vec%0d freq_ok", i), 32'(capFreq), 32'(tbl[i].expFreq));
`ifdef DUTY_CHECK_EN
            checkOutput($sformatf("vec%0d duty_ok", i), 32'(capDuty), 32'(tbl[i].expDuty));
`endif
        end

        // Input held low: loss, no valid, period holds; recovery needs two rises.
        v0 = validSeen;
        holdLevel(1'b0, 300);
        checkOutput("low-loss lost", 32'(lost), 32'd1);
        checkOutput("low-loss no valid", 32'(validSeen - v0), 32'd0);
        checkOutput("low-loss period held", 32'(period), 32'(tbl[8].expPeriod));
        applyStimulus(50, 50);
        checkOutput("restart first rise no valid", 32'(validSeen - v0), 32'd0);
        checkOutput("restart lost still set", 32'(lost), 32'd1);
        applyStimulus(50, 50);
        holdLevel(1'b0, 4);
        checkOutput("restart valids", 32'(validSeen - v0), 32'd1);
        checkOutput("restart period", 32'(capPeriod), 32'd100);
        checkOutput("restart lost cleared", 32'(lost), 32'd0);

        // Input stuck high: loss, then the later fall is ignored while idle.
        holdLevel(1'b1, 300);
        checkOutput("stuck-high lost", 32'(lost), 32'd1);
        holdLevel(1'b0, 20);
        applyStimulus(50, 50);
        applyStimulus(50, 50);
        holdLevel(1'b0, 4);
        checkOutput("stuck-high recover period", 32'(period), 32'd100);
        checkOutput("stuck-high recover high", 32'(high_time), 32'd50);
        checkOutput("stuck-high recover lost", 32'(lost), 32'd0);

        // Reset in the middle of a high phase.
        holdLevel(1'b1, 20);
        reset = 1'b1;
        f_in  = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        checkZeroOutputs("mid-reset");
        @(posedge clk);
        #1;
        v0 = validSeen;
        applyStimulus(50, 50);
        checkOutput("post-reset first rise no valid", 32'(validSeen - v0), 32'd0);
        applyStimulus(50, 50);
        holdLevel(1'b0, 4);
        checkOutput("post-reset valids", 32'(validSeen - v0), 32'd1);
        checkOutput("post-reset period", 32'(capPeriod), 32'd100);
        checkOutput("post-reset high_time", 32'(capHigh), 32'd50);

        // Random waves checked cycle by cycle against the model.
        for (int k = 0; k < 30; k++) begin
            h = int'($urandom_range(150, 1));
            l = int'($urandom_range(150, 1));
            if ($urandom_range(5, 0) == 0) begin
                l = int'($urandom_range(280, 200));
            end
            applyStimulus(h, l);
        end
        holdLevel(1'b0, 10);

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule
